// File: rtl/b16_mem_pkg.sv
// b16 memory controller shared types: access regions, controller states
// and the IO window mask.
package b16_mem_pkg;

    typedef enum logic [1:0] {
        REG_IO,
        REG_BOOT,
        REG_SRAM
    } region_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOOT,
        S_IO,
        S_SRAM_ACC,
        S_DONE
    } state_e;

    // Address bits ignored when matching the IO window: the window is the
    // top four bytes of the address space.
    localparam logic [1:0] IO_LOW_MASK = 2'b11;

endpackage

// File: rtl/b16_bootram.sv
// b16 boot RAM: 2**AW x 16-bit sync RAM
// built from two byte lanes with own enables.
module b16_bootram #(
  parameter int    AW     = 12,
  parameter string INIT_L = "",
  parameter string INIT_H = ""
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [7:0] mem_l [2**AW];
  logic [7:0] mem_h [2**AW];

  always_ff @(posedge clk) begin
    if (we_i[0]) mem_l[addr_i] <= wdata_i[7:0];
    if (we_i[1]) mem_h[addr_i] <= wdata_i[15:8];
    rdata_o <= {mem_h[addr_i], mem_l[addr_i]};
  end

endmodule

// File: rtl/b16_memctl.sv
// b16 memory controller: arbitrates CPU/debug masters, decodes IO / boot
// RAM / external SRAM, runs the SRAM wait-state FSM and returns a one-cycle
// ready pulse to the owning master.
// Ports: clk, nreset (async, active low); cpu_* / dbg_* master requests,
// dbg_sel grants debug; rdata, cpu_ready, dbg_ready back to masters;
// io_sel, io_rdata for the IO window; sram_* drive the async SRAM.
// Option: define B16_MEMCTL_BOOT_WP_EN to discard CPU writes to boot RAM.
module b16_memctl
    import b16_mem_pkg::*;
#(
    parameter int    AW          = 16,
    parameter int    BOOT_AW     = 12,
    parameter int    BOOT_BASE   = 1,
    parameter int    SRAM_WAIT   = 3,
    parameter string BOOT_INIT_L = "b16l.hex",
    parameter string BOOT_INIT_H = "b16h.hex"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          dbg_sel,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_r,
    input  logic [1:0]    cpu_w,
    input  logic [15:0]   cpu_wdata,
    input  logic [AW-1:0] dbg_addr,
    input  logic          dbg_r,
    input  logic [1:0]    dbg_w,
    input  logic [15:0]   dbg_wdata,
    output logic [15:0]   rdata,
    output logic          cpu_ready,
    output logic          dbg_ready,
    output logic          io_sel,
    input  logic [15:0]   io_rdata,
    output logic [AW-2:0] sram_addr,
    input  logic [15:0]   sram_dq_i,
    output logic [15:0]   sram_dq_o,
    output logic          sram_dq_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    localparam int BW = AW - BOOT_AW - 1;

    state_e        state_q;
    logic          own_dbg_q;
    logic [AW-1:1] addr_q;
    logic [15:0]   wdata_q;
    logic [1:0]    w_q;
    logic          rd_q;
    logic [3:0]    cnt_q;
    logic [15:0]   rdata_q;
    logic          cpu_ready_q;
    logic          dbg_ready_q;
    logic          ce_n_q;
    logic          oe_n_q;
    logic          we_n_q;
    logic          ub_n_q;
    logic          lb_n_q;
    logic          dq_oe_q;

    logic [AW-1:0] g_addr;
    logic          g_r;
    logic [1:0]    g_w;
    logic [15:0]   g_wdata;
    logic          g_req;
    region_e       g_reg;

    always_comb begin
        g_addr  = dbg_sel ? dbg_addr  : cpu_addr;
        g_r     = dbg_sel ? dbg_r     : cpu_r;
        g_w     = dbg_sel ? dbg_w     : cpu_w;
        g_wdata = dbg_sel ? dbg_wdata : cpu_wdata;
        g_req   = g_r | (|g_w);
        if (&(g_addr | AW'(IO_LOW_MASK)))
            g_reg = REG_IO;
        else if (g_addr[AW-1:BOOT_AW+1] == BW'(BOOT_BASE))
            g_reg = REG_BOOT;
        else
            g_reg = REG_SRAM;
    end

    // Boot RAM read is launched from IDLE with the granted address so the
    // data is ready during the BOOT cycle; writes use the latched address.
    logic              boot_wr_ok;
    logic [BOOT_AW-1:0] ram_addr;
    logic [1:0]        ram_we;
    logic [15:0]       ram_rdata;

`ifdef B16_MEMCTL_BOOT_WP_EN
    assign boot_wr_ok = own_dbg_q;
`else
    assign boot_wr_ok = 1'b1;
`endif

    assign ram_addr = (state_q == S_IDLE) ? g_addr[BOOT_AW:1]
                                          : addr_q[BOOT_AW:1];
    assign ram_we   = (state_q == S_BOOT) ? (w_q & {2{boot_wr_ok}})
                                          : 2'b00;

    b16_bootram #(
        .AW     (BOOT_AW),
        .INIT_L (BOOT_INIT_L),
        .INIT_H (BOOT_INIT_H)
    ) u_bootram (
        .clk     (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            own_dbg_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            w_q         <= 2'b00;
            rd_q        <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (g_req) begin
                        own_dbg_q <= dbg_sel;
                        addr_q    <= g_addr[AW-1:1];
                        wdata_q   <= g_wdata;
                        rd_q      <= g_r;
                        // A read request wins over any write enables.
                        w_q       <= g_r ? 2'b00 : g_w;
                        unique case (g_reg)
                            REG_IO:   state_q <= S_IO;
                            REG_BOOT: state_q <= S_BOOT;
                            default: begin
                                state_q <= S_SRAM_ACC;
                                cnt_q   <= 4'(SRAM_WAIT - 1);
                                ce_n_q  <= 1'b0;
                                oe_n_q  <= ~g_r;
                                ub_n_q  <= g_r ? 1'b0 : ~g_w[1];
                                lb_n_q  <= g_r ? 1'b0 : ~g_w[0];
                                dq_oe_q <= ~g_r;
                            end
                        endcase
                    end
                end
                S_BOOT: begin
                    if (rd_q) rdata_q <= ram_rdata;
                    state_q     <= S_DONE;
                    cpu_ready_q <= ~own_dbg_q;
                    dbg_ready_q <= own_dbg_q;
                end
                S_IO: begin
                    if (rd_q) rdata_q <= io_rdata;
                    state_q     <= S_DONE;
                    cpu_ready_q <= ~own_dbg_q;
                    dbg_ready_q <= own_dbg_q;
                end
                S_SRAM_ACC: begin
                    // First cycle is address setup; we_n falls after it.
                    if (!rd_q) we_n_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        if (rd_q) rdata_q <= sram_dq_i;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                        ub_n_q      <= 1'b1;
                        lb_n_q      <= 1'b1;
                        dq_oe_q     <= 1'b0;
                        state_q     <= S_DONE;
                        cpu_ready_q <= ~own_dbg_q;
                        dbg_ready_q <= own_dbg_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io_sel     = (state_q == S_IO) ||
                        ((state_q == S_IDLE) && g_req && (g_reg == REG_IO));
    assign rdata      = rdata_q;
    assign cpu_ready  = cpu_ready_q;
    assign dbg_ready  = dbg_ready_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = wdata_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_b16_memctl.sv
// Self-checking bench for b16_memctl: directed scenarios plus randomized
// transactions checked against a behavioural model of the memory map.
module tb_b16_memctl;

    localparam int W = 3;

    logic        clk;
    logic        nreset;
    logic        dbg_sel;
    logic [15:0] cpu_addr;
    logic        cpu_r;
    logic [1:0]  cpu_w;
    logic [15:0] cpu_wdata;
    logic [15:0] dbg_addr;
    logic        dbg_r;
    logic [1:0]  dbg_w;
    logic [15:0] dbg_wdata;
    logic [15:0] rdata;
    logic        cpu_ready;
    logic        dbg_ready;
    logic        io_sel;
    logic [15:0] io_rdata;
    logic [14:0] sram_addr;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    b16_memctl #(
        .AW          (16),
        .BOOT_AW     (12),
        .BOOT_BASE   (1),
        .SRAM_WAIT   (W),
        .BOOT_INIT_L (""),
        .BOOT_INIT_H ("")
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .dbg_sel    (dbg_sel),
        .cpu_addr   (cpu_addr),
        .cpu_r      (cpu_r),
        .cpu_w      (cpu_w),
        .cpu_wdata  (cpu_wdata),
        .dbg_addr   (dbg_addr),
        .dbg_r      (dbg_r),
        .dbg_w      (dbg_w),
        .dbg_wdata  (dbg_wdata),
        .rdata      (rdata),
        .cpu_ready  (cpu_ready),
        .dbg_ready  (dbg_ready),
        .io_sel     (io_sel),
        .io_rdata   (io_rdata),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: first eight boot words and the last completed read.
    logic [15:0] boot_m [8];
    logic [15:0] last_rd;
    bit          wp;

    int t_lat;
    int t_wrong;
    int t_io;
    bit t_done;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 0 = IO, 1 = boot RAM, 2 = SRAM
    function automatic int region_of(input logic [15:0] a);
        if (a >= 16'hFFFC) return 0;
        if ((a >> 13) == 16'd1) return 1;
        return 2;
    endfunction

    // One complete transaction; called just after a rising edge while idle.
    task automatic xact(input bit dbg, input logic [15:0] a, input bit r,
                        input logic [1:0] w, input logic [15:0] wd,
                        input logic [15:0] dq, input logic [15:0] iod);
        int rk, lat, ce_lo, oe_lo, we_lo, dqe, bad_ln, bad_ad, bad_dq;
        int io_seen, wrong, exp_lat, idx;
        bit wr, done;
        logic [15:0] exp_rd;
        rk = region_of(a);
        wr = !r && (w != 2'b00);
        idx = int'(a[3:1]);
        dbg_sel = dbg;
        if (dbg) begin
            dbg_addr = a; dbg_r = r; dbg_w = w; dbg_wdata = wd;
            cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        end else begin
            cpu_addr = a; cpu_r = r; cpu_w = w; cpu_wdata = wd;
            dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom);
        end
        sram_dq_i = dq;
        io_rdata = iod;
        lat = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; dqe = 0;
        bad_ln = 0; bad_ad = 0; bad_dq = 0; io_seen = 0; wrong = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!sram_ce_n) begin
                ce_lo++;
                if (sram_addr !== a[15:1]) bad_ad++;
                if ({sram_ub_n, sram_lb_n} !== (wr ? ~w : 2'b00)) bad_ln++;
            end
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (sram_dq_oe) begin
                dqe++;
                if (sram_dq_o !== wd) bad_dq++;
            end
            if (io_sel) io_seen++;
            if (dbg ? cpu_ready : dbg_ready) wrong++;
            if (dbg ? dbg_ready : cpu_ready) done = 1;
            else lat++;
        end
        exp_rd = last_rd;
        if (r) begin
            if (rk == 0) exp_rd = iod;
            else if (rk == 1) exp_rd = boot_m[idx];
            else exp_rd = dq;
        end else if (wr && rk == 1 && (dbg || !wp)) begin
            if (w[0]) boot_m[idx][7:0] = wd[7:0];
            if (w[1]) boot_m[idx][15:8] = wd[15:8];
        end
        exp_lat = (rk == 2) ? W + 1 : 2;
        chk("done", 32'(done), 1);
        chk("latency", lat, exp_lat);
        chk("rdata", rdata, exp_rd);
        last_rd = exp_rd;
        chk("wrong_ready", wrong, 0);
        chk("ce_low", ce_lo, (rk == 2) ? W : 0);
        chk("oe_low", oe_lo, (rk == 2 && r) ? W : 0);
        chk("we_low", we_lo, (rk == 2 && wr) ? W - 1 : 0);
        chk("dq_oe", dqe, (rk == 2 && wr) ? W : 0);
        chk("lanes", bad_ln, 0);
        chk("sram_addr", bad_ad, 0);
        chk("dq_o", bad_dq, 0);
        chk("io_sel", 32'(io_seen > 0), 32'(rk == 0));
        @(posedge clk);
        #1;
        cpu_r = 0; cpu_w = 0; dbg_r = 0; dbg_w = 0;
        @(negedge clk);
        chk("one_pulse", {cpu_ready, dbg_ready}, 0);
        chk("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n,
                             sram_ub_n, sram_lb_n}, 5'h1F);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] a;
        int mode;
        int rk;
        bit d;
`ifdef B16_MEMCTL_BOOT_WP_EN
        wp = 1'b1;
`else
        wp = 1'b0;
`endif
        last_rd = 16'h0000;
        nreset = 0; dbg_sel = 0;
        cpu_addr = 0; cpu_r = 0; cpu_w = 0; cpu_wdata = 0;
        dbg_addr = 0; dbg_r = 0; dbg_w = 0; dbg_wdata = 0;
        io_rdata = 0; sram_dq_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_ready", {cpu_ready, dbg_ready}, 0);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n,
                            sram_ub_n, sram_lb_n}, 5'h1F);
        chk("rst_sram_addr", sram_addr, 0);
        nreset = 1;
        @(posedge clk);
        #1;

        // Load known contents into the boot words used below.
        for (int k = 0; k < 8; k++)
            xact(1, 16'h2000 + 16'(2 * k), 0, 2'b11,
                 (k == 0) ? 16'h1234 : 16'($urandom), 0, 0);

        xact(0, 16'h2000, 1, 2'b00, 0, 16'hAAAA, 16'hBBBB);
        xact(0, 16'h8000, 0, 2'b01, 16'hABCD, 0, 0);
        xact(0, 16'h8000, 1, 2'b00, 0, 16'h55AA, 0);
        xact(0, 16'hFFFB, 0, 2'b10, 16'h5A5A, 0, 0);
        xact(1, 16'hFFFD, 1, 2'b00, 0, 0, 16'hC0DE);
        xact(0, 16'h2002, 1, 2'b11, 16'hDEAD, 0, 0);
        xact(1, 16'h2002, 1, 2'b00, 0, 0, 0);

        // CPU SRAM read; debug takes dbg_sel one cycle in.
        dbg_sel = 0; cpu_addr = 16'h8000; cpu_r = 1; cpu_w = 0;
        sram_dq_i = 16'h0F0F;
        dbg_addr = 16'hFFFC; dbg_r = 1; dbg_w = 0; io_rdata = 16'hBEEF;
        t_lat = 0; t_wrong = 0; t_done = 0;
        for (int c = 0; c < 40 && !t_done; c++) begin
            @(negedge clk);
            if (dbg_ready) t_wrong++;
            if (cpu_ready) t_done = 1;
            else t_lat++;
            if (c == 0) begin
                @(posedge clk);
                #1;
                dbg_sel = 1;
            end
        end
        chk("arb_cpu_done", 32'(t_done), 1);
        chk("arb_cpu_lat", t_lat, W + 1);
        chk("arb_cpu_rdata", rdata, 16'h0F0F);
        chk("arb_cpu_no_dbg", t_wrong, 0);
        @(posedge clk);
        #1;
        cpu_r = 0;
        t_lat = 0; t_wrong = 0; t_done = 0; t_io = 0;
        for (int c = 0; c < 40 && !t_done; c++) begin
            @(negedge clk);
            if (cpu_ready) t_wrong++;
            if (io_sel) t_io++;
            if (dbg_ready) t_done = 1;
            else t_lat++;
        end
        chk("arb_dbg_done", 32'(t_done), 1);
        chk("arb_dbg_lat", t_lat, 2);
        chk("arb_dbg_rdata", rdata, 16'hBEEF);
        chk("arb_dbg_no_cpu", t_wrong, 0);
        chk("arb_io_sel", 32'(t_io > 0), 1);
        last_rd = 16'hBEEF;
        @(posedge clk);
        #1;
        dbg_r = 0; dbg_sel = 0;
        @(posedge clk);
        #1;

        // Reset during the second cycle of an SRAM write.
        cpu_addr = 16'h9000; cpu_w = 2'b11; cpu_r = 0; cpu_wdata = 16'h1111;
        repeat (3) @(negedge clk);
        chk("rst_mid_we", sram_we_n, 0);
        nreset = 0;
        #1;
        chk("rst_mid_strobes", {sram_ce_n, sram_oe_n, sram_we_n,
                                sram_ub_n, sram_lb_n}, 5'h1F);
        chk("rst_mid_dq_oe", sram_dq_oe, 0);
        cpu_w = 0;
        repeat (2) @(negedge clk);
        nreset = 1;
        t_wrong = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (cpu_ready || dbg_ready) t_wrong++;
        end
        chk("rst_mid_no_ready", t_wrong, 0);
        chk("rst_mid_rdata", rdata, 0);
        last_rd = 16'h0000;
        @(posedge clk);
        #1;
        xact(0, 16'h2004, 1, 2'b00, 0, 0, 0);

        // Boot write protection (depends on build option).
        xact(0, 16'h2000, 0, 2'b11, 16'hFFFF, 0, 0);
        xact(0, 16'h2000, 1, 2'b00, 0, 0, 0);
        xact(1, 16'h2000, 0, 2'b11, 16'hFFFF, 0, 0);
        xact(0, 16'h2000, 1, 2'b00, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            d = 1'($urandom % 2);
            rk = int'($urandom % 3);
            mode = int'($urandom % 4);
            if (rk == 0) a = 16'hFFFC | 16'($urandom % 4);
            else if (rk == 1) a = 16'h2000 | 16'($urandom % 16);
            else begin
                a = 16'($urandom);
                while (region_of(a) != 2) a = 16'($urandom);
            end
            xact(d, a, (mode == 0 || mode == 2),
                 (mode == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
